// File: rtl/pmem_responder_pkg.sv
// Shared types and constants for the pmem_* bus responder.
// Words use PDP-10 bit numbering (bit 0 is the MSB, bit 35 the LSB).
package pmem_responder_pkg;

  localparam int WORD_W  = 36;
  localparam int PADDR_W = 22;

  typedef logic [0:WORD_W-1] word_t;
  typedef logic [14:35]      paddr_t;

  localparam logic [6:0] MEM_DEV_DEFAULT = 7'o70;

  typedef enum logic [3:0] {
    MEMR_IDLE    = 4'b0001,
    MEMR_BUSY    = 4'b0010,
    MEMR_ACK     = 4'b0100,
    MEMR_RECOVER = 4'b1000
  } memr_state_t;

  typedef enum logic [1:0] {
    OP_WRITE    = 2'd0,
    OP_READ     = 2'd1,
    OP_IO_WRITE = 2'd2,
    OP_IO_READ  = 2'd3
  } memr_op_t;

  // I/O request address: device code in bits 27:33, bit 34 selects CONx over DATAx.
  function automatic logic [6:0] io_dev(input paddr_t a);
    return 7'(a >> 2);
  endfunction

  function automatic logic io_con(input paddr_t a);
    return 1'(a >> 1);
  endfunction

endpackage

// File: rtl/pmem_if.sv
// pmem_* bus between an initiator (master) and the physical-memory responder (slave).
interface pmem_if;
  import pmem_responder_pkg::*;

  // Handshake: the initiator raises exactly one request level and holds it, with
  // addr/write_data stable, until the matching ack pulses for one cycle. read_data
  // and nxm are meaningful only in that ack cycle. A level still high in the ack
  // cycle is treated as a new request once the responder is idle again.
  paddr_t addr;
  word_t  write_data;
  logic   write;
  logic   read;
  logic   io_write;
  logic   io_read;
  word_t  read_data;
  logic   read_ack;
  logic   write_ack;
  logic   nxm;

  modport master (
    output addr, write_data, write, read, io_write, io_read,
    input  read_data, read_ack, write_ack, nxm
  );

  modport slave (
    input  addr, write_data, write, read, io_write, io_read,
    output read_data, read_ack, write_ack, nxm
  );

endinterface

// File: rtl/pmem_ram.sv
// Single-port synchronous word RAM with registered read, shaped for block-RAM inference.
module pmem_ram
  import pmem_responder_pkg::*;
#(
  parameter int DEPTH = 65536,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  word_t         wdata,
  output word_t         rdata
);

  word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/pmem_responder.sv
// Physical-memory responder: serialises pmem_* requests, backs memory with a word RAM,
// flags non-existent memory and exposes a MEM I/O device that raises PI requests.
module pmem_responder
  import pmem_responder_pkg::*;
#(
  parameter int         SIZE_WORDS = 65536,
  parameter int         LATENCY    = 3,
  parameter logic [6:0] MEM_DEV    = MEM_DEV_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  pmem_if.slave       pmem,
  output logic [1:7]  pi_out,
  output memr_state_t state_dbg
);

  localparam int          AW       = (SIZE_WORDS > 1) ? $clog2(SIZE_WORDS) : 1;
  localparam logic [31:0] SIZE_LIM = 32'(SIZE_WORDS);
  localparam logic [3:0]  MEM_CNT  = 4'(LATENCY - 1);

  memr_state_t state, state_nx;
  memr_op_t    op_q, op_nx, req_op;
  paddr_t      addr_q, addr_nx;
  word_t       data_q, data_nx;
  logic [3:0]  count_q, count_nx;

  logic        nxm_flag;
  logic [2:0]  pi_level;
  paddr_t      last_nxm_addr;

  logic        any_req, mem_op, mem_nxm, io_hit, acc_nxm, ram_we;
  logic [AW-1:0] ram_addr;
  word_t       ram_rdata, io_rdata;

  assign any_req = pmem.write | pmem.read | pmem.io_write | pmem.io_read;

  always_comb begin
    req_op = OP_IO_READ;
    if (pmem.write)         req_op = OP_WRITE;
    else if (pmem.read)     req_op = OP_READ;
    else if (pmem.io_write) req_op = OP_IO_WRITE;
  end

  always_comb begin
    state_nx = state;
    op_nx    = op_q;
    addr_nx  = addr_q;
    data_nx  = data_q;
    count_nx = count_q;
    unique case (state)
      MEMR_IDLE: begin
        if (any_req) begin
          op_nx    = req_op;
          addr_nx  = pmem.addr;
          data_nx  = pmem.write_data;
          count_nx = (req_op == OP_WRITE || req_op == OP_READ) ? MEM_CNT : 4'd0;
          state_nx = (count_nx == 4'd0) ? MEMR_ACK : MEMR_BUSY;
        end
      end
      MEMR_BUSY: begin
        count_nx = count_q - 4'd1;
        if (count_nx == 4'd0) state_nx = MEMR_ACK;
      end
      MEMR_ACK:     state_nx = MEMR_RECOVER;
      MEMR_RECOVER: state_nx = MEMR_IDLE;
      default:      state_nx = MEMR_IDLE;
    endcase
  end

  assign mem_op   = (op_q == OP_WRITE) || (op_q == OP_READ);
  assign mem_nxm  = 32'(addr_q) >= SIZE_LIM;
  assign io_hit   = io_dev(addr_q) == MEM_DEV;
  assign acc_nxm  = mem_op ? mem_nxm : !io_hit;
  assign io_rdata = io_con(addr_q) ? {32'b0, nxm_flag, pi_level} : {14'b0, last_nxm_addr};

  // In IDLE the RAM reads the incoming address so data is ready even when LATENCY is 1.
  assign ram_addr = AW'((state == MEMR_IDLE) ? pmem.addr : addr_q);
  assign ram_we   = (state == MEMR_ACK) && (op_q == OP_WRITE) && !mem_nxm;

  pmem_ram #(.DEPTH(SIZE_WORDS), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (data_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    pmem.read_ack  = 1'b0;
    pmem.write_ack = 1'b0;
    pmem.nxm       = 1'b0;
    pmem.read_data = '0;
    if (state == MEMR_ACK) begin
      pmem.nxm = acc_nxm;
      if (op_q == OP_READ || op_q == OP_IO_READ) begin
        pmem.read_ack = 1'b1;
        if (!acc_nxm) pmem.read_data = (op_q == OP_READ) ? ram_rdata : io_rdata;
      end else begin
        pmem.write_ack = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= MEMR_IDLE;
      op_q          <= OP_WRITE;
      addr_q        <= '0;
      data_q        <= '0;
      count_q       <= '0;
      nxm_flag      <= 1'b0;
      pi_level      <= 3'd0;
      last_nxm_addr <= '0;
      pi_out        <= '0;
    end else begin
      state   <= state_nx;
      op_q    <= op_nx;
      addr_q  <= addr_nx;
      data_q  <= data_nx;
      count_q <= count_nx;
      // Side effects commit on the edge that ends the ack cycle.
      if (state == MEMR_ACK) begin
        if (mem_op && mem_nxm) begin
          nxm_flag      <= 1'b1;
          last_nxm_addr <= addr_q;
        end
        if (op_q == OP_IO_WRITE && io_hit && io_con(addr_q)) begin
          pi_level <= data_q[33:35];
          if (data_q[32]) nxm_flag <= 1'b0;
        end
      end
      for (int l = 1; l <= 7; l++) begin
        pi_out[l] <= nxm_flag && (pi_level == 3'(l));
      end
    end
  end

  assign state_dbg = state;

endmodule
